decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 114 +++++++++++
 tb/tb_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (g=111,101) convolutional code.
// Register-exchange survivors of depth 16 with 8-bit path metrics normalised every symbol.
module decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  localparam int unsigned NS  = 4;
  localparam int unsigned D   = 16;
  localparam int unsigned PMW = 8;
  localparam logic [PMW-1:0] PM_ZERO  = 8'd0;
  localparam logic [PMW-1:0] PM_OTHER = 8'd16;

  logic [PMW-1:0] pm_r      [NS];
  logic [D-1:0]   sv_r      [NS];
  logic           d_out_r;

  logic [PMW:0]   acs_s     [NS];
  logic [D-1:0]   sv_next_s [NS];
  logic [PMW-1:0] pm_next_s [NS];
  logic [PMW:0]   min_s;
  logic [1:0]     best_s;

  // Code symbol {c1,c0} emitted when input u leaves encoder state pred={s1,s0}
  function automatic logic [1:0] branch_symbol(input logic [1:0] pred, input logic u);
    branch_symbol = {u ^ pred[1] ^ pred[0], u ^ pred[0]};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2)
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x        = a ^ b;
    hamming2 = {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Add-compare-select per next state {u,a}; on a tie the predecessor {a,0} is kept
  always_comb begin
    logic [1:0]   nxt_v;
    logic [1:0]   p0_v;
    logic [1:0]   p1_v;
    logic         u_v;
    logic [PMW:0] c0_v;
    logic [PMW:0] c1_v;
    nxt_v = 2'b00;
    p0_v  = 2'b00;
    p1_v  = 2'b00;
    u_v   = 1'b0;
    c0_v  = 9'd0;
    c1_v  = 9'd0;
    for (int n = 0; n < NS; n++) begin
      nxt_v = 2'(n);
      u_v   = nxt_v[1];
      p0_v  = {nxt_v[0], 1'b0};
      p1_v  = {nxt_v[0], 1'b1};
      c0_v  = {1'b0, pm_r[p0_v]} + {7'd0, hamming2(d_in, branch_symbol(p0_v, u_v))};
      c1_v  = {1'b0, pm_r[p1_v]} + {7'd0, hamming2(d_in, branch_symbol(p1_v, u_v))};
      if (c1_v < c0_v) begin
        acs_s[n]     = c1_v;
        sv_next_s[n] = D'({sv_r[p1_v], u_v});
      end else begin
        acs_s[n]     = c0_v;
        sv_next_s[n] = D'({sv_r[p0_v], u_v});
      end
    end
  end

  // Smallest new metric and the lowest-index state holding it
  always_comb begin
    min_s  = acs_s[0];
    best_s = 2'd0;
    for (int n = 1; n < NS; n++) begin
      if (acs_s[n] < min_s) begin
        min_s  = acs_s[n];
        best_s = 2'(n);
      end else begin
        min_s  = min_s;
        best_s = best_s;
      end
    end
  end

  // Normalise so the best metric is zero; metric spread stays far below 2^8
  always_comb begin
    for (int n = 0; n < NS; n++) begin
      pm_next_s[n] = PMW'(acs_s[n] - min_s);
    end
  end

  // Metric, survivor and output registers; everything holds while enable is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_r[0] <= PM_ZERO;
      for (int n = 1; n < NS; n++) begin
        pm_r[n] <= PM_OTHER;
      end
      for (int n = 0; n < NS; n++) begin
        sv_r[n] <= 16'd0;
      end
      d_out_r <= 1'b0;
    end else if (enable) begin
      for (int n = 0; n < NS; n++) begin
        pm_r[n] <= pm_next_s[n];
        sv_r[n] <= sv_next_s[n];
      end
      d_out_r <= sv_next_s[best_s][D-1];
    end
  end

  assign d_out = d_out_r;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for the Viterbi decoder: reference encoder, table vectors,
// expected-bit scoreboard queue, error injection, enable gaps and async reset.
module tb_decoder;

  typedef struct {
    logic [1:0] d_in;
    logic       exp;
  } vec_t;

  localparam int STRESS_N = 10000;
  localparam int TBL_N    = 24;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] d_in   = 2'b00;
  logic       d_out;

  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];
  vec_t tbl[TBL_N];
  logic u_mem[STRESS_N];

  decoder dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d_in   (d_in),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] enc(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_pm(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_pms(input string name);
    check_pm({name, "_pm0"}, dut.pm_r[0], 8'd0);
    check_pm({name, "_pm1"}, dut.pm_r[1], 8'd16);
    check_pm({name, "_pm2"}, dut.pm_r[2], 8'd16);
    check_pm({name, "_pm3"}, dut.pm_r[3], 8'd16);
  endtask

  // Drive one accepted symbol, queue its expected bit, compare after the edge
  task automatic apply_sym(input string name, input logic [1:0] sym, input logic exp);
    logic got_exp;
    enable = 1'b1;
    d_in   = sym;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_queue: got empty scoreboard expected one entry", name);
    end else begin
      got_exp = exp_q.pop_front();
      check_bit(name, d_out, got_exp);
    end
  endtask

  task automatic do_reset(input string name);
    enable = 1'b1;
    d_in   = 2'b11;
    rst    = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_bit({name, "_dout"}, d_out, 1'b0);
    check_reset_pms(name);
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // err_mode: 0 clean, 1 fixed errors (sym 3 one bit, sym 20 both bits), 2 sparse random
  task automatic run_stream(input string name, input int n, input bit gaps, input int err_mode);
    logic [1:0] st;
    logic [1:0] sym;
    logic       held;
    logic       exp_bit;
    int         last_err;
    int         gap_len;
    st       = 2'b00;
    held     = 1'b0;
    last_err = -100;
    for (int j = 0; j < n; j++) begin
      sym = enc(u_mem[j], st);
      st  = {u_mem[j], st[1]};
      if (err_mode == 1) begin
        if (j == 3) sym = sym ^ 2'b01;
        if (j == 20) sym = sym ^ 2'b11;
      end else if (err_mode == 2) begin
        if ((j - last_err) >= 8 && $urandom_range(0, 3) == 0) begin
          sym      = sym ^ (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
          last_err = j;
        end
      end
      if (gaps && j > 0 && $urandom_range(0, 2) == 0) begin
        gap_len = $urandom_range(1, 3);
        for (int g = 0; g < gap_len; g++) begin
          enable = 1'b0;
          d_in   = 2'($urandom_range(0, 3));
          @(posedge clk);
          #1;
          check_bit({name, "_hold"}, d_out, held);
        end
      end
      exp_bit = (j < 15) ? 1'b0 : u_mem[j-15];
      apply_sym(name, sym, exp_bit);
      held = exp_bit;
    end
    enable = 1'b0;
  endtask

  initial begin
    logic [1:0] head [9];
    logic       msg  [8];
    head = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
    msg  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < TBL_N; j++) begin
      tbl[j].d_in = (j < 9) ? head[j] : 2'b00;
      tbl[j].exp  = (j >= 15 && j < 23) ? msg[j-15] : 1'b0;
    end

    // Reset with enable high and d_in=11
    do_reset("reset");

    // Clean stream from the table
    for (int j = 0; j < TBL_N; j++) begin
      apply_sym("clean", tbl[j].d_in, tbl[j].exp);
    end

    // All-zero input
    do_reset("zero_rst");
    for (int j = 0; j < 100; j++) begin
      apply_sym("zero", 2'b00, 1'b0);
      check_pm("zero_pm0", dut.pm_r[0], 8'd0);
    end

    // Asynchronous reset mid-stream while d_out is high, then full restart
    do_reset("mid_rst");
    for (int j = 0; j < 18; j++) begin
      apply_sym("pre_mid", tbl[j].d_in, tbl[j].exp);
    end
    #2;
    rst = 1'b0;
    #1;
    check_bit("async_rst_dout", d_out, 1'b0);
    check_reset_pms("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int j = 0; j < TBL_N; j++) begin
      apply_sym("restart", tbl[j].d_in, tbl[j].exp);
    end

    // Fixed channel errors on the same message
    for (int j = 0; j < 40; j++) begin
      u_mem[j] = (j < 8) ? msg[j] : 1'b0;
    end
    do_reset("err_rst");
    run_stream("errfix", 40, 1'b0, 1);

    // Enable gaps between symbols
    do_reset("gap_rst");
    run_stream("gaps", 40, 1'b1, 0);

    // Random stress with sparse single-bit errors
    for (int j = 0; j < STRESS_N; j++) begin
      u_mem[j] = 1'($urandom_range(0, 1));
    end
    do_reset("stress_rst");
    run_stream("stress", STRESS_N, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
